// File: rtl/run_monitor_pkg.sv
// run_monitor_pkg: shared types for the run monitor.
// The optional feature macro RUN_MONITOR_SKIP_ZERO_EN is consumed by run_monitor.sv.
package run_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DUMP = 2'd2,
        DONE = 2'd3
    } run_state_t;

    localparam int CNT_W_DEF = 32;

    // One interrupt schedule slot at the default counter width
    typedef logic [CNT_W_DEF-1:0] irq_slot_t;

    // Index width for a register file of n entries (never below one bit)
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/run_monitor_irq_sched.sv
// run_monitor_irq_sched: registered interrupt pulse generator.
// Each slot is compared against the counter value of the coming cycle so the
// pulse leaves a flop aligned with the RUN cycle whose counter matches.
module run_monitor_irq_sched
    import run_monitor_pkg::*;
#(
    parameter int CNT_W      = 32,
    parameter int NUM_IRQ    = 2,
    parameter int MAX_CLOCKS = 100000
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_run_next,
    input  logic [CNT_W-1:0]         i_cnt_next,
    input  logic [NUM_IRQ*CNT_W-1:0] i_irq_at,
    output logic                     o_interrupt
);

    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_CLOCKS);

    logic w_hit;
    logic r_irq;

    // OR of all enabled slots that can still be reached before the watchdog
    always_comb begin
        w_hit = 1'b0;
        for (int k = 0; k < NUM_IRQ; k++) begin
            if ((i_irq_at[k*CNT_W +: CNT_W] != '0) &&
                (i_irq_at[k*CNT_W +: CNT_W] < CNT_LIMIT) &&
                (i_irq_at[k*CNT_W +: CNT_W] == i_cnt_next)) begin
                w_hit = 1'b1;
            end
        end
    end

    // Pulse register; forced low whenever the next cycle is not a RUN cycle
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= i_run_next && w_hit;
        end
    end

    assign o_interrupt = r_irq;

endmodule

// File: rtl/run_monitor.sv
// run_monitor: run control, cycle watchdog, interrupt injection and register dump.
// Optional macro RUN_MONITOR_SKIP_ZERO_EN: dump only nonzero snapshot registers.
module run_monitor
    import run_monitor_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int NUM_REGS   = 32,
    parameter int MAX_CLOCKS = 100000,
    parameter int CNT_W      = 32,
    parameter int NUM_IRQ    = 2,
    localparam int IDX_W     = idx_width(NUM_REGS)
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_start,
    input  logic [NUM_IRQ*CNT_W-1:0]  i_irq_at,
    input  logic                      i_completed,
    input  logic [NUM_REGS*XLEN-1:0]  i_regs,
    output logic                      o_cpu_run,
    output logic                      o_interrupt,
    output logic                      o_dump_valid,
    input  logic                      i_dump_ready,
    output logic [IDX_W-1:0]          o_dump_idx,
    output logic [XLEN-1:0]           o_dump_data,
    output logic                      o_dump_last,
    output logic                      o_done,
    output logic                      o_timeout,
    output logic [CNT_W-1:0]          o_cycles
);

    localparam logic [CNT_W-1:0] CNT_WD  = CNT_W'(MAX_CLOCKS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_CLOCKS);
    localparam logic [CNT_W-1:0] CNT_SAT = '1;

    run_state_t                 r_state;
    run_state_t                 w_state_next;
    logic [CNT_W-1:0]           r_cnt;
    logic [CNT_W-1:0]           w_cnt_next;
    logic [CNT_W-1:0]           r_cycles;
    logic                       r_timeout;
    logic [NUM_REGS*XLEN-1:0]   r_snap;
    logic [IDX_W-1:0]           r_idx;
    logic [IDX_W-1:0]           w_cur;
    logic                       w_found;
    logic                       w_last;
    logic                       w_wd;
    logic                       w_hs;

`ifdef RUN_MONITOR_SKIP_ZERO_EN
    logic w_more;

    // Lookahead: first nonzero register at or after r_idx, and whether any follows it
    always_comb begin
        w_found = 1'b0;
        w_more  = 1'b0;
        w_cur   = r_idx;
        for (int k = 0; k < NUM_REGS; k++) begin
            if ((k >= int'(r_idx)) && (r_snap[k*XLEN +: XLEN] != '0)) begin
                if (w_found) begin
                    w_more = 1'b1;
                end else begin
                    w_found = 1'b1;
                    w_cur   = IDX_W'(k);
                end
            end
        end
        w_last = w_found && !w_more;
    end
`else
    // Every register is emitted in order
    assign w_found = 1'b1;
    assign w_cur   = r_idx;
    assign w_last  = (r_idx == IDX_W'(NUM_REGS - 1));
`endif

    assign w_wd = (r_cnt == CNT_WD);
    assign w_hs = (r_state == DUMP) && w_found && i_dump_ready;

    // Counter value of the coming cycle, used by the interrupt scheduler
    always_comb begin
        if (r_state == RUN) begin
            w_cnt_next = (r_cnt == CNT_SAT) ? r_cnt : r_cnt + 1'b1;
        end else begin
            w_cnt_next = '0;
        end
    end

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE, DONE: if (i_start) w_state_next = RUN;
            RUN:        if (i_completed || w_wd) w_state_next = DUMP;
            DUMP:       if (!w_found || (w_hs && w_last)) w_state_next = DONE;
            default:    w_state_next = IDLE;
        endcase
    end

    // Counter, status latches, snapshot and dump index
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt     <= '0;
            r_cycles  <= '0;
            r_timeout <= 1'b0;
            r_snap    <= '0;
            r_idx     <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (i_start) begin
                        r_cnt     <= '0;
                        r_timeout <= 1'b0;
                        r_idx     <= '0;
                    end
                end
                RUN: begin
                    // Completion wins over the watchdog in the same cycle
                    if (i_completed) begin
                        r_cycles  <= r_cnt;
                        r_timeout <= 1'b0;
                        r_snap    <= i_regs;
                        r_idx     <= '0;
                    end else if (w_wd) begin
                        r_cycles  <= CNT_MAX;
                        r_timeout <= 1'b1;
                        r_snap    <= i_regs;
                        r_idx     <= '0;
                    end else begin
                        r_cnt <= w_cnt_next;
                    end
                end
                DUMP: begin
                    if (w_hs) begin
                        r_idx <= w_last ? '0 : w_cur + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Output decode from the current state and dump cursor
    always_comb begin
        o_cpu_run    = (r_state == RUN);
        o_done       = (r_state == DONE);
        o_dump_valid = (r_state == DUMP) && w_found;
        o_dump_last  = (r_state == DUMP) && w_found && w_last;
        o_dump_idx   = '0;
        o_dump_data  = '0;
        if ((r_state == DUMP) && w_found) begin
            o_dump_idx  = w_cur;
            o_dump_data = r_snap[int'(w_cur)*XLEN +: XLEN];
        end
    end

    assign o_cycles  = r_cycles;
    assign o_timeout = r_timeout;

    run_monitor_irq_sched #(
        .CNT_W      (CNT_W),
        .NUM_IRQ    (NUM_IRQ),
        .MAX_CLOCKS (MAX_CLOCKS)
    ) u_irq_sched (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_run_next  (w_state_next == RUN),
        .i_cnt_next  (w_cnt_next),
        .i_irq_at    (i_irq_at),
        .o_interrupt (o_interrupt)
    );

endmodule
